// File: rtl/texture_mem.sv
// Multi-texture texel store: one-cycle registered read port plus a streaming
// loader that fills a whole texture beat by beat, row index fastest.
module texture_mem #(
    parameter int unsigned CHANNEL_BITS = 2,
    parameter int unsigned TEX_ID_BITS  = 1,
    parameter int unsigned UV_BITS      = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rd_en,
    input  logic [TEX_ID_BITS-1:0]     rd_tex,
    input  logic [UV_BITS-1:0]         rd_col,
    input  logic [UV_BITS-1:0]         rd_row,
    output logic [3*CHANNEL_BITS-1:0]  rd_val,
    output logic                       rd_valid,
    input  logic                       ld_start,
    input  logic [TEX_ID_BITS-1:0]     ld_tex,
    input  logic [3*CHANNEL_BITS-1:0]  ld_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    output logic                       ld_busy,
    output logic                       ld_done
);

    localparam int unsigned W         = 3 * CHANNEL_BITS;
    localparam int unsigned CNT_BITS  = 2 * UV_BITS;
    localparam int unsigned ADDR_BITS = TEX_ID_BITS + CNT_BITS;
    localparam int unsigned DEPTH     = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_BITS-1:0]    cnt;
    logic [CNT_BITS-1:0]    cnt_nxt;
    logic [TEX_ID_BITS-1:0] load_tex;
    logic [TEX_ID_BITS-1:0] load_tex_nxt;
    logic                   wr_en_c;
    logic                   rd_mask_c;
    logic [ADDR_BITS-1:0]   wr_addr_c;
    logic [ADDR_BITS-1:0]   rd_addr_c;

    logic [W-1:0] mem [DEPTH];

    // Loader next-state, counter and write-enable decode.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        load_tex_nxt = load_tex;
        wr_en_c      = 1'b0;
        case (state)
            IDLE: begin
                if (ld_start) begin
                    load_tex_nxt = ld_tex;
                    cnt_nxt      = '0;
                    state_nxt    = LOAD;
                end
            end
            LOAD: begin
                if (ld_valid && ld_ready) begin
                    wr_en_c = 1'b1;
                    cnt_nxt = CNT_BITS'(cnt + 1'b1);
                    if (cnt == '1) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they track the state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            load_tex <= '0;
            ld_ready <= 1'b0;
            ld_busy  <= 1'b0;
            ld_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            load_tex <= load_tex_nxt;
            ld_ready <= (state_nxt == LOAD);
            ld_busy  <= (state_nxt != IDLE);
            ld_done  <= (state_nxt == DONE);
        end
    end

    assign wr_addr_c = {load_tex, cnt};
    assign rd_addr_c = {rd_tex, rd_col, rd_row};
    // A texture being rewritten reads as black so half-loaded content never leaks out.
    assign rd_mask_c = ld_busy && (rd_tex == load_tex);

    // Storage array: single write port, no reset so it maps onto a RAM macro.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_addr_c] <= ld_data;
        end
    end

    // Registered read port; same-edge write is not visible (read-before-write).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_val   <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_val <= rd_mask_c ? W'(0) : mem[rd_addr_c];
            end
        end
    end

endmodule

// File: tb/tb_texture_mem.sv
// Randomized scoreboard bench for texture_mem: loads textures under several
// ld_valid patterns while reading, and checks reads against an array model.
module tb_texture_mem;

    localparam int unsigned CB    = 2;
    localparam int unsigned TB    = 1;
    localparam int unsigned UV    = 6;
    localparam int unsigned W     = 3 * CB;
    localparam int unsigned SIDE  = 1 << UV;
    localparam int unsigned NBEAT = SIDE * SIDE;
    localparam int unsigned NTEX  = 1 << TB;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_en;
    logic [TB-1:0] rd_tex;
    logic [UV-1:0] rd_col;
    logic [UV-1:0] rd_row;
    logic [W-1:0]  rd_val;
    logic          rd_valid;
    logic          ld_start;
    logic [TB-1:0] ld_tex;
    logic [W-1:0]  ld_data;
    logic          ld_valid;
    logic          ld_ready;
    logic          ld_busy;
    logic          ld_done;

    always #5 clk = ~clk;

    texture_mem #(.CHANNEL_BITS(CB), .TEX_ID_BITS(TB), .UV_BITS(UV)) dut (
        .clk(clk), .reset(reset),
        .rd_en(rd_en), .rd_tex(rd_tex), .rd_col(rd_col), .rd_row(rd_row),
        .rd_val(rd_val), .rd_valid(rd_valid),
        .ld_start(ld_start), .ld_tex(ld_tex), .ld_data(ld_data), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done)
    );

    typedef struct {
        bit           chk;
        logic [W-1:0] val;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   model [NTEX*NBEAT];
    bit   known [NTEX*NBEAT];
    bit   model_busy = 1'b0;
    int   model_tex  = 0;
    exp_t expq [$];
    exp_t mon_e;
    logic [W-1:0] last_val = '0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented read result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (reset) begin
            last_val = '0;
        end else if (rd_valid) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_valid_unexpected: got rd_valid=1 expected 0 at %0t", $time);
            end else begin
                mon_e = expq.pop_front();
                if (mon_e.chk) check("rd_val", int'(rd_val), int'(mon_e.val));
            end
            last_val = rd_val;
        end else begin
            check("rd_hold", int'(rd_val), int'(last_val));
        end
    end

    task automatic drive_read(input bit en);
        int   addr;
        exp_t e;
        rd_en  = en;
        rd_tex = TB'($urandom);
        rd_col = UV'($urandom);
        rd_row = UV'($urandom);
        if (en) begin
            addr = int'(rd_tex) * NBEAT + int'(rd_col) * SIDE + int'(rd_row);
            if (model_busy && int'(rd_tex) == model_tex) begin
                e.chk = 1'b1;
                e.val = '0;
            end else begin
                e.chk = known[addr];
                e.val = W'(model[addr]);
            end
            expq.push_back(e);
        end
    endtask

    task automatic fixed_read(input int tex, input int col, input int row, input int exp);
        exp_t e;
        @(negedge clk);
        ld_start = 1'b0;
        ld_valid = 1'b0;
        rd_en  = 1'b1;
        rd_tex = TB'(tex);
        rd_col = UV'(col);
        rd_row = UV'(row);
        e.chk = 1'b1;
        e.val = W'(exp);
        expq.push_back(e);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // mode 0: ld_valid always 1; mode 1: toggling starting at 0; mode 2: random.
    task automatic do_load(input int tex, input int mode, input int stop_after,
                           input bit idx_data, input bit mid_start, input bit with_reads);
        int           b = 0;
        int           cyc = 0;
        int           ready_cyc = 0;
        int           stalls = 0;
        int           exp_ready;
        bit           v;
        logic [W-1:0] d;
        @(negedge clk);
        ld_start = 1'b1;
        ld_tex   = TB'(tex);
        ld_valid = 1'b0;
        drive_read(1'b0);
        @(negedge clk);
        ld_start   = 1'b0;
        model_busy = 1'b1;
        model_tex  = tex;
        while (b < stop_after && cyc < 20000) begin
            if (cyc == 0) check("load_busy", int'(ld_busy), 1);
            if (ld_ready) ready_cyc++;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 1) : 1'($urandom_range(0, 1));
            d = idx_data ? W'(b % 64) : W'($urandom);
            ld_valid = v;
            ld_data  = d;
            ld_start = mid_start && (cyc == 100);
            ld_tex   = (mid_start && cyc == 100) ? TB'(tex + 1) : TB'($urandom);
            drive_read(with_reads && ($urandom_range(0, 1) == 1));
            @(negedge clk);
            cyc++;
            if (v) begin
                model[tex * NBEAT + b] = int'(d);
                known[tex * NBEAT + b] = 1'b1;
                b++;
            end else begin
                stalls++;
            end
        end
        ld_start = 1'b0;
        if (b < stop_after) begin
            total++;
            bad++;
            $display("FAIL load_timeout: got %0d beats expected %0d", b, stop_after);
        end
        if (b == NBEAT) begin
            exp_ready = (mode == 0) ? NBEAT : (mode == 1) ? 2 * NBEAT : NBEAT + stalls;
            check("ready_cycles", ready_cyc, exp_ready);
            check("done_pulse", int'(ld_done), 1);
            check("done_busy", int'(ld_busy), 1);
            check("done_ready", int'(ld_ready), 0);
            ld_valid = 1'b0;
            drive_read(with_reads);
            @(negedge clk);
            model_busy = 1'b0;
            rd_en = 1'b0;
            check("after_done", int'(ld_done), 0);
            check("after_busy", int'(ld_busy), 0);
            check("after_ready", int'(ld_ready), 0);
        end
    endtask

    task automatic idle_reads(input int n);
        ld_start = 1'b0;
        ld_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_read($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rd_en = 1'b0; rd_tex = '0; rd_col = '0; rd_row = '0;
        ld_start = 1'b0; ld_tex = '0; ld_data = '0; ld_valid = 1'b0;
        for (int i = 0; i < NTEX * NBEAT; i++) begin
            model[i] = 0;
            known[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_val", int'(rd_val), 0);
        check("rst_ld_ready", int'(ld_ready), 0);
        check("rst_ld_busy", int'(ld_busy), 0);
        check("rst_ld_done", int'(ld_done), 0);
        #2 reset = 1'b0;

        do_load(1, 0, NBEAT, 1'b1, 1'b0, 1'b1);
        fixed_read(1, 3, 5, 5);
        do_load(0, 1, NBEAT, 1'b1, 1'b1, 1'b1);
        idle_reads(300);

        // Abandon a load part-way through with an asynchronous reset.
        fixed_read(1, 3, 5, 5);
        do_load(1, 0, 100, 1'b1, 1'b0, 1'b0);
        check("pre_rst_busy", int'(ld_busy), 1);
        #2 reset = 1'b1;
        #1;
        check("async_rd_val", int'(rd_val), 0);
        check("async_rd_valid", int'(rd_valid), 0);
        check("async_ld_ready", int'(ld_ready), 0);
        check("async_ld_busy", int'(ld_busy), 0);
        check("async_ld_done", int'(ld_done), 0);
        ld_valid = 1'b0;
        model_busy = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;

        do_load(1, 2, NBEAT, 1'b0, 1'b0, 1'b1);
        fixed_read(1, 0, 0, model[NBEAT]);
        idle_reads(500);
        repeat (3) @(negedge clk);
        check("queue_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
